// File: rtl/adder_share_sched.sv
// Two-requester scheduler that time-shares one 12-bit ripple-carry adder to
// produce a 24-bit add/subtract in two passes (low half, then high half).

module adder_share_add12 (
   input  logic [11:0] a,
   input  logic [11:0] b,
   input  logic        cin,
   output logic [11:0] sum,
   output logic        cout
);

   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < 12; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

module adder_share_sched #(
   parameter int ROUND_ROBIN = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [23:0] req0_a,
   input  logic [23:0] req0_b,
   input  logic        req0_sub,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [23:0] req1_a,
   input  logic [23:0] req1_b,
   input  logic        req1_sub,
   output logic        resp_valid,
   output logic        resp_id,
   output logic [23:0] resp_sum,
   output logic        resp_cout,
   output logic        resp_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic        last_grant;
   logic        grant1;
   logic        accept;

   logic [23:0] op_a;
   logic [23:0] op_b;
   logic        op_cin;
   logic        op_id;
   logic [11:0] lo_sum;
   logic        c12;

   logic [11:0] add_a;
   logic [11:0] add_b;
   logic        add_cin;
   logic [11:0] add_sum;
   logic        add_cout;

   // Overflow only possible when both operands share a sign the result lacks.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   always_comb begin
      grant1     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      state_nx   = state;
      add_a      = op_a[11:0];
      add_b      = op_b[11:0];
      add_cin    = op_cin;

      if (ROUND_ROBIN != 0)
         grant1 = req1_valid && (!req0_valid || !last_grant);
      else
         grant1 = req1_valid && !req0_valid;

      if (reset && state == IDLE) begin
         req0_ready = req0_valid && !grant1;
         req1_ready = grant1;
      end

      case (state)
         IDLE: if (req0_ready || req1_ready) state_nx = LO;
         LO:   state_nx = HI;
         HI:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // The high pass reuses the same adder with the chained carry.
      if (state == HI) begin
         add_a   = op_a[23:12];
         add_b   = op_b[23:12];
         add_cin = c12;
      end
   end

   assign accept = req0_ready || req1_ready;

   adder_share_add12 u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_sum   <= '0;
         resp_cout  <= 1'b0;
         resp_ovf   <= 1'b0;
      end else begin
         state      <= state_nx;
         resp_valid <= (state == HI);
         if (accept)
            last_grant <= req1_ready;
         if (state == HI) begin
            resp_id   <= op_id;
            resp_sum  <= {add_sum, lo_sum};
            resp_cout <= add_cout;
            resp_ovf  <= signed_ovf(op_a[23], op_b[23], add_sum[11]);
         end
      end
   end

   // Operand capture and low-half result: data only, no reset needed.
   always_ff @(posedge clock) begin
      if (accept) begin
         op_id <= req1_ready;
         if (req1_ready) begin
            op_a   <= req1_a;
            op_b   <= req1_sub ? ~req1_b : req1_b;
            op_cin <= req1_sub;
         end else begin
            op_a   <= req0_a;
            op_b   <= req0_sub ? ~req0_b : req0_b;
            op_cin <= req0_sub;
         end
      end
      if (state == LO) begin
         lo_sum <= add_sum;
         c12    <= add_cout;
      end
   end

endmodule

// File: doc/adder_share_sched.md
# adder_share_sched

Time-shares one 12-bit ripple-carry adder between two requesters and uses it twice per operation to produce a 24-bit add/subtract. Low half first, high half second with the carry chained. Sits between the ALU-side requesters (e.g. address-calc and multi-cycle arithmetic units) and the single shared 12-bit adder instance, which is instantiated inside this block. Provides per-requester valid/ready acceptance, round-robin or fixed-priority arbitration, and a one-cycle tagged response pulse.

## Interface
- ROUND_ROBIN, 1, 1 = round-robin between requesters; 0 = fixed priority, req0 always wins.
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 accepted this cycle (combinational).
- req0_a, req0_b  input  24  operands for requester 0.
- req0_sub  input  1  1 = a − b, 0 = a + b.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as above for requester 1.
- resp_valid  output  1  one-cycle pulse; result fields valid.
- resp_id  output  1  requester that owns the result.
- resp_sum  output  24  result, modulo 2^24.
- resp_cout  output  1  carry out of bit 23.
- resp_ovf  output  1  signed two's-complement overflow.

## Operation
- FSM states: IDLE, LO, HI.
  - IDLE → LO on acceptance.
  - LO → HI unconditionally.
  - HI → IDLE unconditionally.
- Acceptance happens only in IDLE with reset deasserted.
  - reqN_ready = (state == IDLE) && reqN_valid && (arbiter grants N).
  - At most one ready is high in any cycle.
  - On acceptance, latch a, b' = sub ? ~b : b, cin = sub, and id.
- Arbitration, ROUND_ROBIN=1:
  - If only one valid, grant it.
  - If both valid, grant the requester not granted last.
  - last_grant resets to 1, so req0 wins the first tie.
  - last_grant updates only on acceptance.
- Arbitration, ROUND_ROBIN=0: req0 wins every tie; last_grant is unused.
- LO: the adder computes a[11:0] + b'[11:0] + cin. Register the low sum and carry c12.
- HI: the adder computes a[23:12] + b'[23:12] + c12. Register the full 24-bit result and cout.
  - ovf = (a[23] == b'[23]) && (sum[23] != a[23]).
  - resp_id = latched id.
- Adder operand muxing is driven only by the FSM state. Exactly one adder instance is permitted.
- Requesters hold valid and operands stable until ready. Operands are sampled only on the acceptance edge; later changes have no effect.
- Dropping valid before ready is allowed; no acceptance occurs.
- No backpressure on the response; consumers capture it on resp_valid.

## Timing
- Reset values while reset = 0, applied at the next clock edge:
  - state = IDLE, resp_valid = 0, resp_sum = 0, resp_cout = 0, resp_ovf = 0, resp_id = 0, last_grant = 1.
  - req0_ready = req1_ready = 0 combinationally while reset = 0.
- Latency, with acceptance in cycle T:
  - LO in T+1, HI in T+2.
  - resp_valid = 1 in T+3 only; result fields hold until the next response.
- Back-to-back: the cycle carrying resp_valid is IDLE, so a new acceptance may occur in it.
  - Maximum throughput is 1 operation per 3 cycles.
- Reset asserted in LO or HI:
  - The in-flight operation is discarded and no resp_valid is issued for it.
  - The next acceptance after reset releases behaves as after power-up.
- Simultaneous resp_valid and a new acceptance are independent; both occur.

## Test plan
- req0 add, a=0x000FFF, b=0x000001, accept at T → resp_valid only at T+3; sum=0x001000, cout=0, ovf=0, id=0 (carry crosses the half boundary).
- req1 sub, a=0x000005, b=0x000007 → sum=0xFFFFFE, cout=0, ovf=0, id=1. Then a=0x7FFFFF + b=0x000001 → sum=0x800000, ovf=1, cout=0.
- Add 0xFFFFFF + 0x000001 → sum=0x000000, cout=1, ovf=0. Sub 0x800000 − 0x000001 → sum=0x7FFFFF, ovf=1, cout=1.
- Both valid held high for 4 operations, ROUND_ROBIN=1 → grants 0,1,0,1; ready pulses 3 cycles apart; resp_id matches each grant. ROUND_ROBIN=0 → grants 0,0,0,0.
- Reset pulsed low during LO → no resp_valid for that operation, all outputs 0. Following req0 add 0x000010 + 0x000020 → sum=0x000030 at accept+3.
- req0 drops valid one cycle before acceptance could occur → no ready and no response. Operands changed after acceptance → result reflects the latched operands only.
